// File: rtl/ysyx_23060072_pipe_ctrl.sv
// Pipeline hazard/flow controller: holds, bubbles, IF/ID flush and PC redirect.
// Optional perf counters are built only when YSYX_23060072_PERF_CNT_EN is defined.
module ysyx_23060072_pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        has_rs1_i,
  input  logic        has_rs2_i,
  input  logic        ex_load_flag_i,
  input  logic [4:0]  ex_wb_reg_waddr_i,
  input  logic        ex_multdiv_en_i,
  input  logic        multdiv_done_i,
  input  logic        lsu_busy_i,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        trap_flag_i,
  input  logic [31:0] trap_addr_i,
  output logic        if_hold_flag_o,
  output logic        id_hold_flag_o,
  output logic        ex_hold_flag_o,
  output logic        clean_flag_o,
  output logic        ifid_flush_o,
  output logic        redirect_valid_o,
`ifdef YSYX_23060072_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT, FLUSH} state_t;

  state_t      state_q, state_d;
  logic        if_hold_d, id_hold_d, ex_hold_d, clean_d, flush_d, redir_d;
  logic [31:0] redir_pc_d;
  logic        load_use;

  // x0 is never a real producer, so it cannot create a load-use hazard.
  assign load_use = ex_load_flag_i && (ex_wb_reg_waddr_i != 5'd0) &&
                    ((has_rs1_i && (id_rs1_addr_i == ex_wb_reg_waddr_i)) ||
                     (has_rs2_i && (id_rs2_addr_i == ex_wb_reg_waddr_i)));

  always_comb begin
    state_d    = RUN;
    if_hold_d  = 1'b0;
    id_hold_d  = 1'b0;
    ex_hold_d  = 1'b0;
    clean_d    = 1'b0;
    flush_d    = 1'b0;
    redir_d    = 1'b0;
    redir_pc_d = 32'd0;
    if (lsu_busy_i) begin
      // A jump/trap sitting in EX is frozen too, so it is served after the wait.
      if_hold_d = 1'b1;
      id_hold_d = 1'b1;
      ex_hold_d = 1'b1;
      state_d   = MEM_WAIT;
    end else if (trap_flag_i || ex_jump_flag_i) begin
      redir_d    = 1'b1;
      redir_pc_d = trap_flag_i ? trap_addr_i : ex_jump_addr_i;
      flush_d    = 1'b1;
      clean_d    = 1'b1;
      state_d    = FLUSH;
    end else if (state_q == FLUSH) begin
      // EX holds a squashed instruction here; its load/multdiv flags are stale.
      flush_d = 1'b1;
      state_d = RUN;
    end else if (ex_multdiv_en_i && !multdiv_done_i) begin
      if_hold_d = 1'b1;
      id_hold_d = 1'b1;
      ex_hold_d = 1'b1;
      state_d   = MD_WAIT;
    end else if (load_use) begin
      if_hold_d = 1'b1;
      id_hold_d = 1'b1;
      clean_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign if_hold_flag_o   = !rst && if_hold_d;
  assign id_hold_flag_o   = !rst && id_hold_d;
  assign ex_hold_flag_o   = !rst && ex_hold_d;
  assign clean_flag_o     = !rst && clean_d;
  assign ifid_flush_o     = !rst && flush_d;
  assign redirect_valid_o = !rst && redir_d;
  assign redirect_pc_o    = rst ? 32'd0 : redir_pc_d;

`ifdef YSYX_23060072_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (if_hold_d || id_hold_d || ex_hold_d) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir_d)                             flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060072_pipe_ctrl.sv
// Self-checking bench for ysyx_23060072_pipe_ctrl: directed scenarios then random traffic,
// each cycle compared against a rule-level reference model.
module tb_ysyx_23060072_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_waddr;
  logic        has_rs1, has_rs2, ex_load, md_en, md_done, lsu_busy, jump, trap;
  logic [31:0] jump_addr, trap_addr;
  logic        if_hold, id_hold, ex_hold, clean, flush, rvalid;
  logic [31:0] rpc;
`ifdef YSYX_23060072_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall, m_flush;
`endif

  int checks = 0;
  int failures = 0;
  logic        m_after_redirect;   // previous cycle issued a redirect
  logic [37:0] exp_v, got_v;

  always #5 clk = ~clk;

  ysyx_23060072_pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .has_rs1_i(has_rs1), .has_rs2_i(has_rs2),
    .ex_load_flag_i(ex_load), .ex_wb_reg_waddr_i(ex_waddr),
    .ex_multdiv_en_i(md_en), .multdiv_done_i(md_done),
    .lsu_busy_i(lsu_busy), .ex_jump_flag_i(jump), .ex_jump_addr_i(jump_addr),
    .trap_flag_i(trap), .trap_addr_i(trap_addr),
    .if_hold_flag_o(if_hold), .id_hold_flag_o(id_hold), .ex_hold_flag_o(ex_hold),
    .clean_flag_o(clean), .ifid_flush_o(flush), .redirect_valid_o(rvalid),
`ifdef YSYX_23060072_PERF_CNT_EN
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
    .redirect_pc_o(rpc)
  );

  // Expected {if_hold,id_hold,ex_hold,clean,flush,redirect,pc} from the hazard rules.
  task automatic model_outputs();
    logic dep;
    dep = ex_load && ex_waddr != 0 &&
          ((has_rs1 && id_rs1_addr == ex_waddr) || (has_rs2 && id_rs2_addr == ex_waddr));
    if (rst)                    exp_v = '0;
    else if (lsu_busy)          exp_v = {3'b111, 3'b000, 32'd0};
    else if (trap || jump)      exp_v = {3'b000, 3'b111, (trap ? trap_addr : jump_addr)};
    else if (m_after_redirect)  exp_v = {3'b000, 3'b010, 32'd0};
    else if (md_en && !md_done) exp_v = {3'b111, 3'b000, 32'd0};
    else if (dep)               exp_v = {3'b110, 3'b100, 32'd0};
    else                        exp_v = '0;
  endtask

  task automatic step(input string tag);
    #1;
    model_outputs();
    got_v = {if_hold, id_hold, ex_hold, clean, flush, rvalid, rpc};
    checks++;
    assert (got_v === exp_v) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
`ifdef YSYX_23060072_PERF_CNT_EN
    checks++;
    assert ({stall_cnt, flush_cnt} === {m_stall, m_flush}) else begin
      failures++;
      $error("FAIL %s_cnt got=%0d/%0d exp=%0d/%0d", tag, stall_cnt, flush_cnt, m_stall, m_flush);
    end
`endif
    @(posedge clk);
    m_after_redirect = !rst && exp_v[32];
`ifdef YSYX_23060072_PERF_CNT_EN
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_stall = m_stall + {31'd0, |exp_v[37:35]};
      m_flush = m_flush + {31'd0, exp_v[32]};
    end
`endif
    #1;
  endtask

  task automatic idle();
    {id_rs1_addr, id_rs2_addr, ex_waddr} = '0;
    {has_rs1, has_rs2, ex_load, md_en, md_done, lsu_busy, jump, trap} = '0;
    jump_addr = 32'h8000_0040;
    trap_addr = 32'h8000_0100;
  endtask

  initial begin
    m_after_redirect = 1'b0;
`ifdef YSYX_23060072_PERF_CNT_EN
    m_stall = 0;
    m_flush = 0;
`endif
    idle();
    rst = 1'b1;
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("idle");

    // Load-use on rs2=x5, then the bubble clears the condition.
    ex_load = 1; ex_waddr = 5; has_rs2 = 1; id_rs2_addr = 5; has_rs1 = 1; id_rs1_addr = 3;
    step("loaduse");
    idle();
    step("loaduse_after");
    ex_load = 1; ex_waddr = 0; has_rs1 = 1; id_rs1_addr = 0;
    step("loaduse_x0");
    idle();

    // Jump, then FLUSH cycle, then idle.
    jump = 1;
    step("jump");
    idle();
    step("jump_flush");
    step("jump_idle");

    // Trap beats jump.
    jump = 1; trap = 1;
    step("trap_jump");
    idle();
    ex_load = 1; ex_waddr = 7; has_rs1 = 1; id_rs1_addr = 7; md_en = 1;
    step("flush_ignores_ex");
    idle();

    // Mult/div held for 33 cycles, released in the done cycle.
    md_en = 1;
    for (int i = 0; i < 33; i++) step("md_wait");
    md_done = 1;
    step("md_done");
    idle();
    step("md_idle");

    // Busy LSU masks a pending jump for 4 cycles.
    jump = 1; jump_addr = 32'h8000_0200;
    lsu_busy = 1;
    for (int i = 0; i < 4; i++) step("mem_wait");
    lsu_busy = 0;
    step("mem_redirect");
    idle();
    step("mem_flush");

    // Reset during a mult/div wait.
    md_en = 1;
    step("md_pre_rst0");
    step("md_pre_rst1");
    rst = 1;
    step("md_rst");
    rst = 0;
    idle();
    step("md_after_rst");

    // Random traffic; small register range makes dependencies frequent.
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_waddr    = 5'($urandom_range(0, 3));
      has_rs1     = 1'($urandom_range(0, 1));
      has_rs2     = 1'($urandom_range(0, 1));
      ex_load     = 1'($urandom_range(0, 1));
      md_en       = ($urandom_range(0, 3) == 0);
      md_done     = ($urandom_range(0, 2) == 0);
      lsu_busy    = ($urandom_range(0, 5) == 0);
      jump        = ($urandom_range(0, 7) == 0);
      trap        = ($urandom_range(0, 15) == 0);
      jump_addr   = $urandom;
      trap_addr   = $urandom;
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
